// File: rtl/config_pkg.sv
// Global configuration record shared by the backend blocks.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{XLEN: 32};

  // Number of CDB write-back ports snooped by issue queues.
  localparam int NumWbDefault = 2;

endpackage

// File: rtl/decode_pkg.sv
// Decoded micro-op format handed from dispatch to the issue stage.
package decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    alu_op_e     op;
    logic        use_imm;
    logic        is_branch;
  } uop_t;

endpackage

// File: rtl/alu_issue_queue_age_matrix.sv
// Age matrix for the issue queue: row i bit j set means entry i is older than entry j.
// Grants the single oldest requesting entry.
module issue_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] grant_o
);

  logic [DEPTH-1:0]            r_age [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] w_blk;

  // A new entry is younger than everything present; a freed entry claims nothing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc_i[i] || free_i[i]) r_age[i][j] <= 1'b0;
          else if (alloc_i[j])         r_age[i][j] <= 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_grant
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_blk
      assign w_blk[gi][gj] = req_i[gj] & r_age[gj][gi];
    end
    assign grant_o[gi] = req_i[gi] & ~(|w_blk[gi]);
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Out-of-order ALU issue queue: buffers uops until both operands are captured,
// issues the oldest ready one per cycle through a registered output stage.
module alu_issue_queue
  import decode_pkg::*;
#(
  parameter config_pkg::cfg_t Cfg    = config_pkg::EmptyCfg,
  parameter int               TAG_W  = 6,
  parameter int               XLEN   = Cfg.XLEN,
  parameter int               DEPTH  = 8,
  parameter int               NUM_WB = config_pkg::NumWbDefault
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          enq_valid_i,
  output logic                          enq_ready_o,
  input  uop_t                          enq_uop_i,
  input  logic [TAG_W-1:0]              enq_rob_tag_i,
  input  logic                          enq_rs1_ready_i,
  input  logic                          enq_rs2_ready_i,
  input  logic [TAG_W-1:0]              enq_rs1_tag_i,
  input  logic [TAG_W-1:0]              enq_rs2_tag_i,
  input  logic [XLEN-1:0]               enq_rs1_data_i,
  input  logic [XLEN-1:0]               enq_rs2_data_i,
  input  logic [NUM_WB-1:0]             cdb_valid_i,
  input  logic [NUM_WB-1:0][TAG_W-1:0]  cdb_tag_i,
  input  logic [NUM_WB-1:0][XLEN-1:0]   cdb_data_i,
  output logic                          alu_valid_o,
  output uop_t                          alu_uop_o,
  output logic [XLEN-1:0]               alu_rs1_data_o,
  output logic [XLEN-1:0]               alu_rs2_data_o,
  output logic [TAG_W-1:0]              alu_rob_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy_o
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } src_t;

  typedef struct packed {
    logic             valid;
    uop_t             uop;
    logic [TAG_W-1:0] rob_tag;
    src_t             rs1;
    src_t             rs2;
  } entry_t;

  // Scanning from the top down lets the lowest matching port win.
  function automatic src_t snoop(input src_t s,
                                 input logic [NUM_WB-1:0] v,
                                 input logic [NUM_WB-1:0][TAG_W-1:0] t,
                                 input logic [NUM_WB-1:0][XLEN-1:0] d);
    src_t r;
    r = s;
    if (!s.rdy) begin
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (v[p] && (t[p] == s.tag)) begin
          r.rdy  = 1'b1;
          r.data = d[p];
        end
      end
    end
    return r;
  endfunction

  entry_t           r_entries [DEPTH];
  logic [OCC_W-1:0] r_occ;
  logic             r_alu_valid;
  uop_t             r_alu_uop;
  logic [XLEN-1:0]  r_alu_rs1;
  logic [XLEN-1:0]  r_alu_rs2;
  logic [TAG_W-1:0] r_alu_tag;

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_req;
  logic [DEPTH-1:0] w_grant;
  logic [DEPTH-1:0] w_alloc_oh;
  logic [DEPTH-1:0] w_alloc;
  logic [DEPTH-1:0] w_free;
  logic             w_enq_fire;
  logic             w_issue;
  src_t             w_enq_rs1;
  src_t             w_enq_rs2;
  entry_t           w_new;
  entry_t           w_sel;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_req
    assign w_valid[gi] = r_entries[gi].valid;
    assign w_req[gi]   = r_entries[gi].valid & r_entries[gi].rs1.rdy & r_entries[gi].rs2.rdy;
  end

  assign enq_ready_o = (r_occ < OCC_W'(DEPTH));
  assign w_enq_fire  = enq_valid_i && enq_ready_o && !flush_i;
  assign w_issue     = (|w_grant) && !flush_i;
  assign w_alloc     = w_enq_fire ? w_alloc_oh : '0;
  assign w_free      = w_issue ? w_grant : '0;

  always_comb begin
    logic found;
    found      = 1'b0;
    w_alloc_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_valid[i] && !found) begin
        w_alloc_oh[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign w_enq_rs1 = '{rdy: enq_rs1_ready_i, tag: enq_rs1_tag_i, data: enq_rs1_data_i};
  assign w_enq_rs2 = '{rdy: enq_rs2_ready_i, tag: enq_rs2_tag_i, data: enq_rs2_data_i};

  // New entries snoop the CDB too, so a producer finishing this cycle is not missed.
  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.uop     = enq_uop_i;
    w_new.rob_tag = enq_rob_tag_i;
    w_new.rs1     = snoop(w_enq_rs1, cdb_valid_i, cdb_tag_i, cdb_data_i);
    w_new.rs2     = snoop(w_enq_rs2, cdb_valid_i, cdb_tag_i, cdb_data_i);
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) w_sel = r_entries[i];
    end
  end

  issue_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .alloc_i (w_alloc),
    .free_i  (w_free),
    .req_i   (w_req),
    .grant_o (w_grant)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_i) begin
          r_entries[i].valid <= 1'b0;
        end else if (w_alloc[i]) begin
          r_entries[i] <= w_new;
        end else if (w_free[i]) begin
          r_entries[i].valid <= 1'b0;
        end else if (r_entries[i].valid) begin
          r_entries[i].rs1 <= snoop(r_entries[i].rs1, cdb_valid_i, cdb_tag_i, cdb_data_i);
          r_entries[i].rs2 <= snoop(r_entries[i].rs2, cdb_valid_i, cdb_tag_i, cdb_data_i);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_occ <= '0;
    end else if (flush_i) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + OCC_W'(w_enq_fire) - OCC_W'(w_issue);
    end
  end

  // Payload only loads on issue so the outputs hold between issues.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alu_valid <= 1'b0;
      r_alu_uop   <= '0;
      r_alu_rs1   <= '0;
      r_alu_rs2   <= '0;
      r_alu_tag   <= '0;
    end else begin
      r_alu_valid <= w_issue;
      if (w_issue) begin
        r_alu_uop <= w_sel.uop;
        r_alu_rs1 <= w_sel.rs1.data;
        r_alu_rs2 <= w_sel.rs2.data;
        r_alu_tag <= w_sel.rob_tag;
      end
    end
  end

  a_occ_bound : assert property (@(posedge clk_i) disable iff (!rst_ni) r_occ <= OCC_W'(DEPTH));

  assign alu_valid_o    = r_alu_valid;
  assign alu_uop_o      = r_alu_uop;
  assign alu_rs1_data_o = r_alu_rs1;
  assign alu_rs2_data_o = r_alu_rs2;
  assign alu_rob_tag_o  = r_alu_tag;
  assign occupancy_o    = r_occ;

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Out-of-order issue queue that sits directly upstream of `execute_alu`. It buffers renamed ALU/branch uops until both source operands are available. Each cycle it picks the oldest ready entry and drives it, with operand values, through an output issue register into `execute_alu`. Operands that are still pending are woken up and captured by snooping the common data bus (CDB) write-back ports.

## Interface
Parameters:
- `Cfg`, default `config_pkg::EmptyCfg`: global configuration.
- `TAG_W`, default 6: ROB tag width. Also used as the physical source tag width.
- `XLEN`, default `Cfg.XLEN`: data width.
- `DEPTH`, default 8: number of queue entries, ≥2.
- `NUM_WB`, default 2: number of CDB write-back ports snooped.

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `flush_i`  in  1: pipeline flush (mispredict redirect).
- `enq_valid_i`  in  1: dispatch offers a uop.
- `enq_ready_o`  out  1: queue can accept this cycle.
- `enq_uop_i`  in  `decode_pkg::uop_t`: decoded uop, including pc, imm and control bits.
- `enq_rob_tag_i`  in  TAG_W: destination ROB tag.
- `enq_rs1_ready_i`, `enq_rs2_ready_i`  in  1 each: operand value is already valid.
- `enq_rs1_tag_i`, `enq_rs2_tag_i`  in  TAG_W each: producer tag when the operand is not ready.
- `enq_rs1_data_i`, `enq_rs2_data_i`  in  XLEN each: operand value when ready.
- `cdb_valid_i`  in  NUM_WB: write-back port valid.
- `cdb_tag_i`  in  NUM_WB×TAG_W: write-back tag.
- `cdb_data_i`  in  NUM_WB×XLEN: write-back data.
- `alu_valid_o`  out  1: issue to ALU.
- `alu_uop_o`  out  `uop_t`: issued uop.
- `alu_rs1_data_o`, `alu_rs2_data_o`  out  XLEN each: issued operands.
- `alu_rob_tag_o`  out  TAG_W: issued ROB tag.
- `occupancy_o`  out  $clog2(DEPTH+1): number of valid entries.

## Operation
- Entry fields: valid, uop, rob_tag, and per source {rdy, tag, data}.
- Enqueue:
  - The handshake is `enq_valid_i && enq_ready_o`.
  - `enq_ready_o = (occupancy < DEPTH)`. It is computed from registered state only, so same-cycle issue does not free a slot for enqueue.
  - The uop is written into the lowest-index free entry.
- Enqueue-time snoop:
  - If a source is not ready and any CDB port in the same cycle has a valid matching tag, the new entry stores that data with rdy=1.
  - This prevents a missed wakeup.
- Wakeup:
  - For every valid entry and each pending source, a CDB match in cycle t sets rdy and captures the data at the end of t.
  - If several ports match, the lowest port index wins. The producer guarantees this cannot happen.
- Select:
  - An entry is ready when valid && rs1.rdy && rs2.rdy.
  - Among ready entries, the oldest by age matrix is selected.
  - On the clock edge, the selected entry is freed and copied into the issue register.
- Issue register:
  - `alu_valid_o` is 1 for exactly one cycle per issued uop.
  - Outputs hold their last payload when `alu_valid_o`=0.
  - The ALU consumes every cycle, so there is no backpressure.
- Flush:
  - At the edge ending a cycle with `flush_i`=1, all entries and the issue register valid bit are cleared.
  - An enqueue in the flush cycle is discarded and a select in that cycle is not issued.
  - Wakeups in that cycle are irrelevant.
- Reset:
  - All entries are invalid and the age matrix is cleared.
  - `alu_valid_o`=0; `alu_uop_o`, data and tag outputs are '0.
  - `occupancy_o`=0, so `enq_ready_o`=1.
  - A reset assertion mid-operation takes effect immediately, because reset is asynchronous.
- Width rule: `occupancy_o` changes by +enq −issue per cycle and saturates at neither end; an overflow is an assertion failure.

## Timing
- Enqueue with both sources ready in cycle t: selectable in t+1, `alu_valid_o` in t+2 at the earliest.
- CDB match in cycle t for the last pending source: selectable in t+1, issued in t+2.
- A dependent uop of an ALU result broadcast on the CDB in cycle t is issued no earlier than t+2. There is no back-to-back speculative wakeup.
- Full queue: `enq_ready_o`=0. It rises in the cycle after the first issue.
- Simultaneous enqueue and issue when full: the enqueue is refused.
- Empty queue: `alu_valid_o`=0 in the next cycle.
- Flush in cycle t: `alu_valid_o`=0 and `occupancy_o`=0 in t+1; `enq_ready_o`=1 in t+1.

## Structure
- `uop_t` stays in `decode_pkg`.
- The `NUM_WB` default lives in `config_pkg` as a named constant.
- The entry struct is declared locally in the module, because it depends on TAG_W and XLEN.
- Sub-module `issue_age_matrix`, parameter DEPTH:
  - Inputs: allocate one-hot, free one-hot, request vector, flush.
  - Output: oldest-request grant one-hot.
  - Row i bit j set means entry i is older than entry j.

## Test plan
- Enqueue ADD, rs1=5, rs2=7, both ready, rob_tag 3, in cycle 0 → `alu_valid_o` in cycle 2 with data 5/7 and tag 3; `occupancy_o` is 1 in cycle 1 and 0 in cycle 2.
- Enqueue with rs1 pending on tag 9, then CDB tag 9 data 0x55 in cycle 4 → issue in cycle 6 with `alu_rs1_data_o`=0x55.
- Enqueue with rs2 pending on tag 12 in the same cycle that CDB broadcasts tag 12 data 0xAA → the entry is ready in the next cycle and issues with rs2=0xAA.
- Fill 8 entries with rs1 pending on tag 1, then wake all with one broadcast → `enq_ready_o`=0 while full; issue order matches enqueue order, one per cycle.
- Queue with 5 entries, `flush_i` pulsed alongside a valid enqueue → next cycle `occupancy_o`=0, `alu_valid_o`=0, no later issue of any flushed uop.
- Assert `rst_ni` low mid-burst → all outputs are at reset values immediately, `enq_ready_o`=1.
